uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter that serialises 8N1 frames onto a single `tx` line. It is the transmit-side companion of the UART receiver in the same serial link. The block buffers bytes in a small FIFO behind a valid/ready handshake. After every stop bit it inserts a mandatory idle gap, so the receiver's post-stop recovery window never overlaps the next start bit.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `BAUD_DIV = CLK_FREQ / BAUD` (integer division; 434 at the defaults). Elaboration fails if `BAUD_DIV < 2`.
- `FIFO_DEPTH`, default 4: byte buffer depth. Must be a power of 2 and ≥ 2.
- `GAP_BITS`, default 1: idle bit periods inserted after each stop bit. Must be ≥ 1.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rstn`, in, 1: reset, asynchronous active-low.
- `tx_valid`, in, 1: source presents `tx_data`.
- `tx_data`, in, 8: byte to send.
- `tx_ready`, out, 1: FIFO not full. Combinational from the FIFO count.
- `tx`, out, 1: serial line, registered, idle high.
- `tx_busy`, out, 1: high while the FSM is in any state other than IDLE.
- `tx_done`, out, 1: one-cycle pulse at the end of each stop bit.
- `fifo_count`, out, `$clog2(FIFO_DEPTH+1)`: bytes currently buffered.

## Operation
- **Push:** a byte is written when `tx_valid && tx_ready` at a rising edge.
  - `tx_valid` with `tx_ready = 0` is ignored. The source holds the data.
- **Pop:** occurs when the FSM leaves IDLE or GAP with the FIFO non-empty.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - Because pop frees a slot, a push is accepted that same cycle even when the FIFO was full.
- **No bypass:** a byte always passes through the FIFO.
- **FSM states:** IDLE, START, DATA, STOP, GAP.
  - IDLE: `tx = 1`. If the FIFO is non-empty: pop into the shift register, drive `tx = 0`, load the bit counter with `BAUD_DIV-1`, go to START.
  - START: when the counter reaches 0, drive `tx = shreg[0]`, set `bit_idx = 0`, reload the counter, go to DATA.
  - DATA: when the counter reaches 0:
    - If `bit_idx == 7`: drive `tx = 1`, go to STOP.
    - Otherwise: increment `bit_idx` and drive the next bit (LSB first).
    - In both cases, reload the counter.
  - STOP: when the counter reaches 0, pulse `tx_done`, reload the counter with `GAP_BITS*BAUD_DIV-1`, go to GAP.
  - GAP: `tx = 1`. When the counter reaches 0:
    - FIFO non-empty: pop and start the next frame on the same edge, exactly as IDLE does.
    - FIFO empty: go to IDLE.
- **Counter width:** `$clog2(GAP_BITS*BAUD_DIV)`, counting down only, never wrapping.
- **FIFO storage:**
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Full/empty status comes from `fifo_count`.
  - Wrapped pointers must not corrupt data order.
- **Reset** (asynchronous, any time including mid-frame):
  - `tx = 1`, state IDLE, FIFO emptied.
  - `fifo_count = 0`, `tx_busy = 0`, `tx_done = 0`.
  - `tx_ready = 1` after release.
  - A partially sent frame is abandoned; the line simply stays high.

## Timing
- **Start latency:** push at edge E0 into an empty FIFO while IDLE → `tx` falls at edge E1 (one cycle after the push).
- **Bit boundaries:** bit k (start = 0, data 1..8, stop = 9) occupies edges `E1 + k*BAUD_DIV` through `E1 + (k+1)*BAUD_DIV`. Each bit is exactly `BAUD_DIV` cycles.
- **`tx_done`:** high for the single cycle following edge `E1 + 10*BAUD_DIV`.
- **GAP end:** at edge `E1 + (10+GAP_BITS)*BAUD_DIV`.
- **Back-to-back:** consecutive start-bit falling edges are exactly `(10+GAP_BITS)*BAUD_DIV` cycles apart.
- **`tx_busy`:** rises at E1. Falls at the GAP end only if the FIFO is empty.
- **`fifo_count`:** updates on the edge following the push/pop.

## Test plan
- **Single byte** (`CLK_FREQ=1000`, `BAUD=100`, so `BAUD_DIV=10`): push 0xA5 while idle → `tx` low 1 cycle after the push. Bits sampled every 10 cycles read 0,1,0,1,0,0,1,0,1,1. `tx_done` pulses once at cycle 100 after the fall. `tx_busy` drops at cycle 110.
- **Burst / back-pressure:** push 0x01..0x06 on consecutive cycles with `FIFO_DEPTH=4` → `tx_ready` deasserts after 5 bytes are accepted (the first is popped immediately). 0x06 is held until a slot frees. All six bytes go out in order. Start edges are spaced exactly 110 cycles apart.
- **Simultaneous push/pop at full:** FIFO full, push on the GAP-end edge → byte accepted, `fifo_count` stays 4.
- **Loopback:** connect `tx` to the receiver at the default parameters and send 256 random bytes back-to-back → every byte is received intact with no framing errors. No start bit falls inside the receiver's gap window.
- **Reset mid-frame:** assert `rstn` low during data bit 3 with 2 bytes queued → `tx = 1` immediately and `fifo_count = 0`. After release there is no transmission until a new push; the next push transmits cleanly.
- **Wrap-around:** push and transmit 10 bytes through a depth-4 FIFO with staggered pushes → output order matches input order across pointer wrap.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a byte FIFO and a mandatory idle gap after each stop bit
// Ports:
//    clk        - sole clock, rising edge
//    rstn       - asynchronous active-low reset
//    tx_valid   - source presents tx_data
//    tx_data    - byte to send
//    tx_ready   - a byte offered now will be accepted
//    tx         - registered serial line, idle high
//    tx_busy    - FSM is outside IDLE
//    tx_done    - one-cycle pulse at the end of each stop bit
//    fifo_count - bytes currently buffered
module uart_tx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_BITS   = 1
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             tx_valid,
   input  logic [7:0]                       tx_data,
   output logic                             tx_ready,
   output logic                             tx,
   output logic                             tx_busy,
   output logic                             tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CW = $clog2(GAP_BITS * BAUD_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] BIT_LOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_BITS * BAUD_DIV - 1);
   localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

   if (BAUD_DIV < 2) begin : g_bad_div
      $error("uart_tx: BAUD_DIV must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (GAP_BITS < 1) begin : g_bad_gap
      $error("uart_tx: GAP_BITS must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic           push;
   logic           pop;

   // A frame starts whenever the FSM may leave IDLE/GAP and a byte is waiting.
   assign pop      = fifo_count != '0 && (state == IDLE || (state == GAP && cnt == '0));
   // The slot freed by a same-cycle pop is offered to the source, so a full FIFO keeps streaming.
   assign tx_ready = fifo_count != FULL || pop;
   assign push     = tx_valid && tx_ready;
   assign tx_busy  = state != IDLE;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         wptr       <= push ? wptr + 1'b1 : wptr;
         rptr       <= pop ? rptr + 1'b1 : rptr;
         fifo_count <= fifo_count + NW'(push) - NW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state != IDLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else begin
            case (state)
               IDLE, GAP: begin
                  if (pop) begin
                     shreg <= mem[rptr];
                     tx    <= 1'b0;
                     cnt   <= BIT_LOAD;
                     state <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end
               START: begin
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
                  cnt     <= BIT_LOAD;
                  state   <= DATA;
               end
               DATA: begin
                  cnt <= BIT_LOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
               STOP: begin
                  tx_done <= 1'b1;
                  cnt     <= GAP_LOAD;
                  state   <= GAP;
               end
               default: begin
                  tx    <= 1'b1;
                  state <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at BAUD_DIV=10, FIFO_DEPTH=4, GAP_BITS=1
module tb_uart_tx;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;
   logic [2:0] fifo_count;

   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   int         frames = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   bit         mbusy = 1'b0;
   int         mpos = 0;
   logic [9:0] mbits = '0;
   logic [7:0] mexp;

   uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4), .GAP_BITS(1)) dut (
      .clk(clk),
      .rstn(rstn),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .tx(tx),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Line monitor: decodes frames at mid-bit and pops the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mbusy = 1'b0;
         end else if (!mbusy) begin
            if (tx === 1'b0) begin
               mbusy = 1'b1;
               mpos = 0;
               starts.push_back(cyc);
            end
         end else begin
            mpos++;
            if (mpos % 10 == 5) mbits[mpos / 10] = tx;
            if (mpos == 95) begin
               mbusy = 1'b0;
               frames++;
               check("start_bit", 32'(mbits[0]), 32'd0);
               check("stop_bit", 32'(mbits[9]), 32'd1);
               check("frame_queued", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  mexp = exp_q.pop_front();
                  check("data_byte", 32'(mbits[8:1]), 32'(mexp));
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b, output int acc, output int stall);
      int n;
      n = 0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = b;
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("push_timeout", 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
      exp_q.push_back(b);
      acc = cyc;
      stall = n;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((tx_busy || exp_q.size() != 0) && n < 5000);
      if (n >= 5000) check("idle_timeout", 32'(tx_busy), 32'd0);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int e0, s, a, n, f0, lows;
      int done_n, done_at, busy_rise, busy_fall;
      int acc[6];
      int stl[6];
      logic [7:0] vals[10];
      int gaps[10];
      vals = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h10, 8'hEF, 8'h24};
      gaps = '{0, 0, 2, 0, 130, 0, 0, 40, 0, 250};

      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(tx_ready), 32'd1);

      starts.delete();
      push_byte(8'hA5, e0, s);
      done_n = 0;
      done_at = 0;
      busy_rise = 0;
      busy_fall = 0;
      repeat (130) begin
         @(negedge clk);
         if (tx_done) begin
            done_n++;
            done_at = cyc;
         end
         if (tx_busy && busy_rise == 0) busy_rise = cyc;
         if (!tx_busy && busy_rise != 0 && busy_fall == 0) busy_fall = cyc;
      end
      check("start_latency", 32'(starts.size() > 0 ? starts[0] - e0 : -1), 32'd1);
      check("busy_rise", 32'(busy_rise - e0), 32'd1);
      check("done_pulses", 32'(done_n), 32'd1);
      check("done_cycle", 32'(done_at - e0), 32'd101);
      check("busy_fall", 32'(busy_fall - e0), 32'd111);
      wait_idle();

      starts.delete();
      for (int i = 0; i < 6; i++) begin
         push_byte(8'(i + 1), acc[i], stl[i]);
         if (i == 4) begin
            check("full_count", 32'(fifo_count), 32'd4);
            check("full_ready", 32'(tx_ready), 32'd0);
         end
      end
      check("stall_first5", 32'(stl[0] + stl[1] + stl[2] + stl[3] + stl[4]), 32'd0);
      check("stall_sixth", 32'(stl[5] > 0), 32'd1);
      check("pushpop_edge", 32'(acc[5] - acc[0]), 32'd111);
      check("pushpop_count", 32'(fifo_count), 32'd4);
      wait_idle();
      check("burst_frames", 32'(starts.size()), 32'd6);
      if (starts.size() > 0) check("burst_latency", 32'(starts[0] - acc[0]), 32'd1);
      for (int i = 1; i < 6; i++)
         if (i < starts.size()) check("start_spacing", 32'(starts[i] - starts[i-1]), 32'd110);

      for (int i = 0; i < 10; i++) begin
         push_byte(vals[i], a, s);
         repeat (gaps[i]) @(negedge clk);
      end
      wait_idle();
      check("wrap_empty", 32'(fifo_count), 32'd0);

      starts.delete();
      push_byte(8'h11, a, s);
      push_byte(8'h22, a, s);
      push_byte(8'h33, a, s);
      n = 0;
      while ((starts.size() == 0 || cyc < starts[0] + 44) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("pre_reset_count", 32'(fifo_count), 32'd2);
      check("pre_reset_busy", 32'(tx_busy), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_busy", 32'(tx_busy), 32'd0);
      check("mid_rst_done", 32'(tx_done), 32'd0);
      exp_q.delete();
      f0 = frames;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(tx_ready), 32'd1);
      lows = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("post_rst_line_idle", 32'(lows), 32'd0);
      check("post_rst_no_frame", 32'(frames - f0), 32'd0);
      push_byte(8'h96, a, s);
      wait_idle();
      check("post_rst_frame", 32'(frames - f0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
